shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_step.sv | 19 +
 rtl/shift_sequencer.sv | 89 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants, state encoding and direction codes for the multi-cycle
// shift sequencer and its single-step shifter.
package shift_pkg;

  localparam int WIDTH    = 32;
  localparam int SHAMT_W  = 5;
  localparam int STEP_MAX = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by 0..7 bit positions,
// left or right, filling vacated bits with zero.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = shift_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       step,
  input  logic             dir,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (dir == DIR_RIGHT) result = data >> step;
    else                  result = data << step;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative logical shifter: accepts one request in IDLE, walks the shift
// amount down by at most STEP_MAX per cycle, then holds the result in DONE.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH    = shift_pkg::WIDTH,
  parameter int STEP_MAX = shift_pkg::STEP_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   rem;
  logic                 dir;
  logic [2:0]           step;
  logic                 last_step;
  logic [WIDTH-1:0]     shifted;

  // Step is clamped to STEP_MAX; the final step consumes whatever remains.
  always_comb begin
    last_step = (rem <= SHAMT_W'(STEP_MAX));
    step      = last_step ? rem[2:0] : 3'(STEP_MAX);
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data   (acc),
    .step   (step),
    .dir    (dir),
    .result (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      dir   <= DIR_LEFT;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= in_data;
            rem <= in_shamt;
            dir <= in_dir;
          end
        end
        SHIFT: begin
          acc <= shifted;
          rem <= rem - SHAMT_W'(step);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (in_shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc only moves in IDLE-accept and SHIFT, so out_data is frozen in DONE.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    out_data  = acc;
  end

endmodule
